// File: rtl/lsu_pkg.sv
// Shared codes, state encoding and access-size decode for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    localparam logic [1:0] ST_W = 2'b00;
    localparam logic [1:0] ST_H = 2'b01;
    localparam logic [1:0] ST_B = 2'b10;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_BAD} size_e;
    typedef enum logic [1:0] {IDLE, REQ, DONE, FAULT} state_e;

    // Collapse the store/load code into an access width; SZ_BAD marks an illegal code.
    function automatic size_e access_size(input logic mem_write, input logic [1:0] store,
                                          input logic [2:0] load);
        size_e sz;
        sz = SZ_BAD;
        if (mem_write) begin
            case (store)
                ST_W:    sz = SZ_W;
                ST_H:    sz = SZ_H;
                ST_B:    sz = SZ_B;
                default: sz = SZ_BAD;
            endcase
        end else begin
            case (load)
                LD_B, LD_BU: sz = SZ_B;
                LD_H, LD_HU: sz = SZ_H;
                LD_W:        sz = SZ_W;
                default:     sz = SZ_BAD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory req/ack bus between the load/store unit and the memory.
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    input  mem_rdata, mem_ack);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                    output mem_rdata, mem_ack);
endinterface

// File: rtl/load_store_align.sv
// Combinational lane steering for stores and extraction/extension for loads.
module load_store_align
    import lsu_pkg::*;
(
    input  logic        mem_write,
    input  logic [1:0]  store,
    input  logic [2:0]  load,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] write_data,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        illegal
);

    size_e       size_s;
    logic [31:0] shifted_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection, alignment check and load extension.
    always_comb begin
        size_s    = access_size(mem_write, store, load);
        illegal   = (size_s == SZ_BAD);
        shifted_s = mem_rdata >> {addr_lo, 3'b000};
        byte_s    = shifted_s[7:0];
        half_s    = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        misalign  = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = 32'd0;
        case (size_s)
            SZ_W: begin
                misalign  = (addr_lo != 2'b00);
                mem_be    = 4'b1111;
                mem_wdata = write_data;
            end
            SZ_H: begin
                misalign  = addr_lo[0];
                mem_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{write_data[15:0]}};
            end
            SZ_B: begin
                mem_be    = 4'b0001 << addr_lo;
                mem_wdata = {4{write_data[7:0]}};
            end
            default: begin
                mem_be    = 4'b0000;
                mem_wdata = 32'd0;
            end
        endcase
        case (load)
            LD_B:    rdata_ext = {{24{byte_s[7]}}, byte_s};
            LD_H:    rdata_ext = {{16{half_s[15]}}, half_s};
            LD_W:    rdata_ext = mem_rdata;
            LD_BU:   rdata_ext = {24'd0, byte_s};
            LD_HU:   rdata_ext = {16'd0, half_s};
            default: rdata_ext = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory access stage: FSM, wait counter and bus latches.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               MemWrite,
    input  logic [1:0]         Store,
    input  logic [2:0]         Load,
    input  logic [31:0]        Addr,
    input  logic [31:0]        WriteData,
    output logic [31:0]        ReadData,
    output logic               Stall,
    output logic               Done,
    output logic               Fault,
    load_store_unit_if.master  bus
);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  load_q, load_d;
    logic [1:0]  lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;

    logic        in_idle_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] rdata_ext_s;
    logic        misalign_s;
    logic        illegal_s;

    // Outside IDLE the aligner sees the latched access so extraction uses the original lane.
    assign in_idle_s = (state_q == IDLE);

    load_store_align u_align (
        .mem_write  (in_idle_s ? MemWrite  : we_q),
        .store      (Store),
        .load       (in_idle_s ? Load      : load_q),
        .addr_lo    (in_idle_s ? Addr[1:0] : lo_q),
        .write_data (WriteData),
        .mem_rdata  (bus.mem_rdata),
        .mem_be     (be_s),
        .mem_wdata  (wdata_s),
        .rdata_ext  (rdata_ext_s),
        .misalign   (misalign_s),
        .illegal    (illegal_s)
    );

    // Next-state, wait counter and latch updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        lo_d    = lo_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (misalign_s || illegal_s) begin
                        state_d = FAULT;
                    end else begin
                        state_d = REQ;
                        cnt_d   = 8'd0;
                        we_d    = MemWrite;
                        addr_d  = {Addr[31:2], 2'b00};
                        be_d    = be_s;
                        wdata_d = wdata_s;
                        load_d  = Load;
                        lo_d    = Addr[1:0];
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    state_d = DONE;
                    cnt_d   = 8'd0;
                    rdata_d = we_q ? 32'd0 : rdata_ext_s;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = FAULT;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_d = (state_d == REQ);
    end

    // State and latch registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'b0000;
            wdata_q <= 32'd0;
            load_q  <= 3'b000;
            lo_q    <= 2'b00;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            lo_q    <= lo_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;

    assign Done     = (state_q == DONE) || (state_q == FAULT);
    assign Fault    = (state_q == FAULT);
    assign ReadData = (state_q == DONE) ? rdata_q : 32'd0;
    assign Stall    = start && (state_q != DONE) && (state_q != FAULT);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a per-cycle expectation model and literal pins.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset, start, MemWrite;
    logic [1:0]  Store;
    logic [2:0]  Load;
    logic [31:0] Addr, WriteData, ReadData;
    logic        Stall, Done, Fault;

    load_store_unit_if bus_if ();

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .MemWrite(MemWrite), .Store(Store),
        .Load(Load), .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
        .Stall(Stall), .Done(Done), .Fault(Fault), .bus(bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          chk_en = 1'b0;
    logic        exp_stall, exp_done, exp_fault, exp_req;
    bit          exp_bus_chk, exp_wd_chk, exp_rd_chk;
    logic        exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;

    logic [31:0] last_rdata, last_addr, last_wdata;
    logic [3:0]  last_be;
    logic        last_we;
    int          stall_cnt, req_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, expv, $time);
        end
    endtask

    // Bytes accessed, 0 for an illegal code.
    function automatic int msize(input bit mw, input logic [1:0] st, input logic [2:0] ld);
        if (mw) return (st == 2'd0) ? 4 : (st == 2'd1) ? 2 : (st == 2'd2) ? 1 : 0;
        return (ld == 3'd0 || ld == 3'd3) ? 1 : (ld == 3'd1 || ld == 3'd4) ? 2 : (ld == 3'd2) ? 4 : 0;
    endfunction

    function automatic logic [3:0] mbe(input int sz, input logic [31:0] a);
        int m;
        m = ((1 << sz) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] mwdata(input int sz, input logic [31:0] wd);
        if (sz == 4) return wd;
        if (sz == 2) return (wd & 32'h0000FFFF) * 32'h00010001;
        return (wd & 32'h000000FF) * 32'h01010101;
    endfunction

    function automatic logic [31:0] mload(input logic [2:0] ld, input logic [31:0] rd, input logic [31:0] a);
        logic [31:0] v;
        int sz;
        sz = msize(1'b0, 2'd0, ld);
        if (sz == 4) return rd;
        v = (rd >> (8 * (a % 4))) & ((sz == 1) ? 32'h000000FF : 32'h0000FFFF);
        if (ld == 3'd0 && v >= 32'd128)   v = v - 32'd256;
        if (ld == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
        return v;
    endfunction

    // Compare DUT outputs with the current expectations and record values for literal pins.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", Stall, exp_stall);
            chk("done", Done, exp_done);
            chk("fault", Fault, exp_fault);
            chk("mem_req", bus_if.mem_req, exp_req);
            if (exp_rd_chk) chk("read_data", ReadData, exp_rdata);
            if (exp_bus_chk) begin
                chk("mem_we", bus_if.mem_we, exp_we);
                chk("mem_addr", bus_if.mem_addr, exp_addr);
                chk("mem_be", bus_if.mem_be, exp_be);
                if (exp_wd_chk) chk("mem_wdata", bus_if.mem_wdata, exp_wdata);
            end
        end
        if (Done) last_rdata = ReadData;
        if (Stall) stall_cnt++;
        if (bus_if.mem_req) begin
            req_cnt++;
            last_addr  = bus_if.mem_addr;
            last_be    = bus_if.mem_be;
            last_wdata = bus_if.mem_wdata;
            last_we    = bus_if.mem_we;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic s, input logic d, input logic f, input logic r);
        exp_stall = s; exp_done = d; exp_fault = f; exp_req = r;
    endtask

    // One access starting in the current cycle; returns in the idle cycle after Done.
    task automatic access(input bit mw, input logic [1:0] st, input logic [2:0] ld,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int waits, input bit never_ack);
        int  sz, nreq;
        bit  flt;
        sz  = msize(mw, st, ld);
        flt = (sz == 0) ? 1'b1 : ((int'(a[1:0]) % sz) != 0);
        start = 1'b1; MemWrite = mw; Store = st; Load = ld; Addr = a; WriteData = wd;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        exp_bus_chk = 1'b0; exp_rd_chk = 1'b0;
        next_cycle();
        if (!flt) begin
            nreq = never_ack ? TO : waits + 1;
            for (int i = 0; i < nreq; i++) begin
                set_exp(1'b1, 1'b0, 1'b0, 1'b1);
                exp_bus_chk = 1'b1; exp_wd_chk = mw; exp_we = mw;
                exp_addr = a & 32'hFFFFFFFC; exp_be = mbe(sz, a); exp_wdata = mwdata(sz, wd);
                bus_if.mem_ack   = (!never_ack && i == waits);
                bus_if.mem_rdata = rd;
                next_cycle();
                bus_if.mem_ack = 1'b0;
            end
        end
        exp_bus_chk = 1'b0;
        if (flt || never_ack) begin
            set_exp(1'b0, 1'b1, 1'b1, 1'b0);
            exp_rd_chk = 1'b1; exp_rdata = 32'd0;
        end else begin
            set_exp(1'b0, 1'b1, 1'b0, 1'b0);
            exp_rd_chk = !mw; exp_rdata = mload(ld, rd, a);
        end
        next_cycle();
        start = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        exp_rd_chk = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; MemWrite = 1'b0; Store = 2'd0; Load = 3'd0;
        Addr = 32'd0; WriteData = 32'd0;
        bus_if.mem_ack = 1'b0; bus_if.mem_rdata = 32'd0;
        stall_cnt = 0; req_cnt = 0;
        repeat (3) next_cycle();

        // Reset values, checked while reset is still held.
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        exp_bus_chk = 1'b1; exp_wd_chk = 1'b1; exp_rd_chk = 1'b1;
        exp_we = 1'b0; exp_addr = 32'd0; exp_be = 4'b0000; exp_wdata = 32'd0; exp_rdata = 32'd0;
        chk_en = 1'b1;
        next_cycle();
        reset = 1'b0;
        next_cycle();
        exp_bus_chk = 1'b0; exp_rd_chk = 1'b0;

        // Word load, ack in first REQ cycle.
        stall_cnt = 0;
        access(1'b0, 2'd0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 0, 1'b0);
        chk("lw_rdata", last_rdata, 32'hDEADBEEF);
        chk("lw_addr", last_addr, 32'h00000100);
        chk("lw_be", {28'd0, last_be}, 32'h0000000F);
        chk("lw_stall_cycles", 32'(stall_cnt), 32'd2);
        next_cycle();

        // lb then lbu back-to-back at 0x103.
        access(1'b0, 2'd0, 3'b000, 32'h103, 32'd0, 32'h80FF7F01, 0, 1'b0);
        chk("lb_rdata", last_rdata, 32'hFFFFFF80);
        chk("lb_be", {28'd0, last_be}, 32'h00000008);
        access(1'b0, 2'd0, 3'b011, 32'h103, 32'd0, 32'h80FF7F01, 1, 1'b0);
        chk("lbu_rdata", last_rdata, 32'h00000080);
        chk("lbu_be", {28'd0, last_be}, 32'h00000008);
        next_cycle();

        // Halfword store with three wait cycles.
        stall_cnt = 0;
        access(1'b1, 2'b01, 3'd0, 32'h202, 32'h1234ABCD, 32'd0, 3, 1'b0);
        chk("sh_we", {31'd0, last_we}, 32'd1);
        chk("sh_be", {28'd0, last_be}, 32'h0000000C);
        chk("sh_wdata", last_wdata, 32'hABCDABCD);
        chk("sh_addr", last_addr, 32'h00000200);
        chk("sh_stall_cycles", 32'(stall_cnt), 32'd5);

        // Further patterns: sb, lh (sign), lhu, sw.
        access(1'b1, 2'b10, 3'd0, 32'h301, 32'h0000005A, 32'd0, 0, 1'b0);
        chk("sb_wdata", last_wdata, 32'h5A5A5A5A);
        access(1'b0, 2'd0, 3'b001, 32'h102, 32'd0, 32'h8001_1234, 2, 1'b0);
        chk("lh_rdata", last_rdata, 32'hFFFF8001);
        access(1'b0, 2'd0, 3'b100, 32'h100, 32'd0, 32'h8001_F234, 0, 1'b0);
        chk("lhu_rdata", last_rdata, 32'h0000F234);
        access(1'b1, 2'b00, 3'd0, 32'h10C, 32'hCAFEF00D, 32'd0, 1, 1'b0);
        next_cycle();

        // Misaligned and illegal accesses: no bus request at all.
        req_cnt = 0;
        access(1'b0, 2'd0, 3'b010, 32'h101, 32'd0, 32'd0, 0, 1'b0);
        access(1'b1, 2'b01, 3'd0, 32'h203, 32'h1111, 32'd0, 0, 1'b0);
        access(1'b0, 2'd0, 3'b101, 32'h100, 32'd0, 32'd0, 0, 1'b0);
        access(1'b1, 2'b11, 3'd0, 32'h100, 32'd0, 32'd0, 0, 1'b0);
        chk("fault_no_req", 32'(req_cnt), 32'd0);
        next_cycle();

        // Timeout, followed by a late ack that must be ignored.
        req_cnt = 0;
        access(1'b0, 2'd0, 3'b010, 32'h400, 32'd0, 32'h12345678, 0, 1'b1);
        chk("timeout_req_cycles", 32'(req_cnt), 32'd4);
        bus_if.mem_ack = 1'b1;
        next_cycle();
        bus_if.mem_ack = 1'b0;
        next_cycle();

        // Reset during REQ of a store.
        start = 1'b1; MemWrite = 1'b1; Store = 2'b00; Addr = 32'h400; WriteData = 32'h55AA55AA;
        set_exp(1'b1, 1'b0, 1'b0, 1'b0);
        next_cycle();
        set_exp(1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0; start = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0);
        exp_bus_chk = 1'b1; exp_wd_chk = 1'b1; exp_rd_chk = 1'b1;
        exp_we = 1'b0; exp_addr = 32'd0; exp_be = 4'b0000; exp_wdata = 32'd0; exp_rdata = 32'd0;
        next_cycle();
        exp_bus_chk = 1'b0; exp_rd_chk = 1'b0;
        access(1'b0, 2'd0, 3'b010, 32'h404, 32'd0, 32'h0BADCAFE, 0, 1'b0);
        chk("post_reset_lw", last_rdata, 32'h0BADCAFE);
        next_cycle();
        next_cycle();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
